// File: rtl/hud_status.sv
// hud_status: BCD score and lives state with a HUD overlay renderer.
// Score adds run digit-serially; the pixel output is registered.
module hud_status #(
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_LIVES    = 3,
  parameter int BLINK_FRAMES = 32,
  parameter int HUD_Y        = 20,
  parameter int SCORE_X      = 40,
  parameter int LIVES_X      = 500
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame_start,
  input  logic [9:0]                       pix_x,
  input  logic [9:0]                       pix_y,
  input  logic [3:0]                       scale,
  input  logic                             game_reset,
  input  logic                             add_valid,
  input  logic [7:0]                       add_bcd,
  output logic                             add_ready,
  input  logic                             life_lost,
  input  logic                             life_gain,
  output logic [$clog2(MAX_LIVES+1)-1:0]   lives,
  output logic                             game_over,
  output logic [4*NUM_DIGITS-1:0]          score_bcd,
  output logic [2:0]                       rgb
);

  localparam int LW = $clog2(MAX_LIVES+1);
  localparam int BW = $clog2(BLINK_FRAMES+1);
  localparam int SW = 4*NUM_DIGITS;
  localparam logic [SW-1:0] NINES = {NUM_DIGITS{4'h9}};

  localparam logic [103:0] SHIP = {
    13'b0000001000000,
    13'b0000011100000,
    13'b0000011100000,
    13'b0111111111110,
    13'b1111111111111,
    13'b1111111111111,
    13'b1111111111111,
    13'b1111111111111
  };

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    COMMIT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   work;
  logic [SW-1:0]   work_nx;
  logic [7:0]      op;
  logic [2:0]      k;
  logic            carry;
  logic            carry_nx;
  logic [3:0]      cur;
  logic [3:0]      opk;
  logic [4:0]      sum;
  logic [BW-1:0]   blink;
  logic [LW-1:0]   ghost;
  logic            lose;
  logic            gain;
  logic            blink_on;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  function automatic logic [34:0] font(input logic [3:0] c);
    logic [34:0] g;
    case (c)
      4'd0:  g = 35'b01110_10001_10011_10101_11001_10001_01110;
      4'd1:  g = 35'b00100_01100_00100_00100_00100_00100_01110;
      4'd2:  g = 35'b01110_10001_00001_00010_00100_01000_11111;
      4'd3:  g = 35'b11111_00010_00100_00010_00001_10001_01110;
      4'd4:  g = 35'b00010_00110_01010_10010_11111_00010_00010;
      4'd5:  g = 35'b11111_10000_11110_00001_00001_10001_01110;
      4'd6:  g = 35'b00110_01000_10000_11110_10001_10001_01110;
      4'd7:  g = 35'b11111_00001_00010_00100_01000_01000_01000;
      4'd8:  g = 35'b01110_10001_10001_01110_10001_10001_01110;
      4'd9:  g = 35'b01110_10001_10001_01111_00001_00010_01100;
      4'd10: g = 35'b01111_10000_10000_01110_00001_00001_11110;
      4'd11: g = 35'b01110_10001_10000_10000_10000_10001_01110;
      4'd12: g = 35'b01110_10001_10001_10001_10001_10001_01110;
      4'd13: g = 35'b11110_10001_10001_11110_10100_10010_10001;
      4'd14: g = 35'b11111_10000_10000_11110_10000_10000_11111;
      default: g = '0;
    endcase
    return g;
  endfunction

  function automatic logic [9:0] half_mul(input logic [5:0] n,
                                          input logic [9:0] w);
    logic [15:0] p;
    p = {10'd0, n} * {6'd0, w};
    return 10'(p >> 1);
  endfunction

  function automatic logic text_px(input logic [3:0] code,
                                   input logic [9:0] x0,
                                   input logic [9:0] px,
                                   input logic [9:0] s,
                                   input logic [2:0] row);
    logic [9:0]  dx;
    logic [9:0]  col;
    logic [5:0]  sh;
    logic [34:0] g;
    dx  = px - x0;
    col = dx / s;
    sh  = {3'd0, row} * 6'd5 + {3'd0, col[2:0]};
    g   = font(code) << sh;
    return (px >= x0) && (col < 10'd5) && (g >= 35'h4_0000_0000);
  endfunction

  function automatic logic icon_px(input logic [9:0] x0,
                                   input logic [9:0] px,
                                   input logic [9:0] s,
                                   input logic [2:0] row);
    logic [9:0]   dx;
    logic [9:0]   col;
    logic [6:0]   sh;
    logic [103:0] g;
    dx  = px - x0;
    col = dx / s;
    sh  = {4'd0, row} * 7'd13 + {3'd0, col[3:0]};
    g   = SHIP << sh;
    return (px >= x0) && (col < 10'd13) && (g >= {1'b1, 103'd0});
  endfunction

  // add FSM state register; game_reset aborts any add in flight
  always_ff @(posedge clk) begin
    if (!rst_n || game_reset) state <= IDLE;
    else                      state <= state_nx;
  end

  // add FSM next state and handshake
  always_comb begin
    state_nx  = state;
    add_ready = 1'b0;
    unique case (state)
      IDLE: begin
        add_ready = 1'b1;
        if (add_valid) state_nx = ADD;
      end
      ADD:     if (k == 3'(NUM_DIGITS-1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // one BCD digit of work + operand per cycle, saturating on final carry
  always_comb begin
    cur      = 4'(work >> {k, 2'b00});
    opk      = (k == 3'd0) ? op[3:0] : (k == 3'd1) ? op[7:4] : 4'd0;
    sum      = {1'b0, cur} + {1'b0, opk} + {4'd0, carry};
    work_nx  = work;
    carry_nx = 1'b0;
    if (sum > 5'd9) begin
      work_nx[{k, 2'b00} +: 4] = 4'(sum - 5'd10);
      carry_nx = 1'b1;
    end else begin
      work_nx[{k, 2'b00} +: 4] = sum[3:0];
    end
    if (carry_nx && k == 3'(NUM_DIGITS-1)) work_nx = NINES;
  end

  // score datapath: latch operand, accumulate, commit whole result at once
  always_ff @(posedge clk) begin
    if (!rst_n || game_reset) begin
      score_bcd <= '0;
      work      <= '0;
      op        <= '0;
      k         <= '0;
      carry     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (add_valid) begin
          op    <= {clamp9(add_bcd[7:4]), clamp9(add_bcd[3:0])};
          work  <= score_bcd;
          k     <= '0;
          carry <= 1'b0;
        end
        ADD: begin
          work  <= work_nx;
          carry <= carry_nx;
          k     <= k + 3'd1;
        end
        COMMIT:  score_bcd <= work;
        default: ;
      endcase
    end
  end

  assign lose = life_lost && !life_gain && (lives != '0);
  assign gain = life_gain && !life_lost && (lives != LW'(MAX_LIVES));
  assign blink_on = (blink != '0) && blink[2];

  // lives counter, game_over flag and lost-icon blink timer
  always_ff @(posedge clk) begin
    if (!rst_n || game_reset) begin
      lives     <= LW'(MAX_LIVES);
      game_over <= 1'b0;
      blink     <= '0;
      ghost     <= '0;
    end else begin
      game_over <= (lives == '0);
      if (lose) begin
        lives <= lives - LW'(1);
        ghost <= lives - LW'(1);
        blink <= BW'(BLINK_FRAMES);
      end else if (gain) begin
        lives <= lives + LW'(1);
        blink <= '0;
      end else if (frame_start && blink != '0) begin
        blink <= blink - BW'(1);
      end
    end
  end

  logic [9:0] s10;
  logic [9:0] cw;
  logic [9:0] sw;
  logic [9:0] dy;
  logic [9:0] row_n;
  logic [2:0] row3;
  logic       in_band;
  logic [3:0] nd;
  logic       lbl;
  logic       dig;
  logic       icn;

  assign s10     = (scale == 4'd0) ? 10'd1 : {6'd0, scale};
  assign cw      = s10 * 10'd5;
  assign sw      = s10 * 10'd13;
  assign dy      = pix_y - 10'(HUD_Y);
  assign row_n   = dy / s10;
  assign row3    = row_n[2:0];
  assign in_band = pix_y >= 10'(HUD_Y);

  // number of digits shown: up to the most significant nonzero one
  always_comb begin
    nd = 4'd1;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (score_bcd[4*d +: 4] != 4'd0) nd = 4'(d + 1);
  end

  // per-pixel hit tests for label, digits and life icons
  always_comb begin
    lbl = 1'b0;
    dig = 1'b0;
    icn = 1'b0;
    for (int i = 0; i < 5; i++)
      lbl = lbl | text_px(4'(10 + i),
                          10'(SCORE_X) + half_mul(6'(3 * i), cw),
                          pix_x, s10, row3);
    if (pix_x >= 10'(SCORE_X) + half_mul(6'd15, cw) &&
        pix_x <  10'(SCORE_X) + half_mul(6'd16, cw) &&
        (row3 == 3'd2 || row3 == 3'd5))
      lbl = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      dig = dig | ((4'(j) < nd) &&
                   text_px(4'(score_bcd >> {nd - 4'(j) - 4'd1, 2'b00}),
                           10'(SCORE_X) + half_mul(6'(17 + 3 * j), cw),
                           pix_x, s10, row3));
    for (int i = 0; i < MAX_LIVES; i++)
      icn = icn | (((LW'(i) < lives) || (blink_on && LW'(i) == ghost)) &&
                   icon_px(10'(LIVES_X) + half_mul(6'(3 * i), sw),
                           pix_x, s10, row3));
    lbl = lbl && in_band && (row_n < 10'd7);
    dig = dig && in_band && (row_n < 10'd7);
    icn = icn && in_band && (row_n < 10'd8);
  end

  // registered pixel: icons over label over digits
  always_ff @(posedge clk) begin
    if (!rst_n)    rgb <= 3'b000;
    else if (icn)  rgb <= 3'b100;
    else if (lbl)  rgb <= 3'b111;
    else if (dig)  rgb <= 3'b010;
    else           rgb <= 3'b000;
  end

endmodule

// File: tb/tb_hud_status.sv
// tb_hud_status: directed checks of hud_status score, lives and pixels.
// Pixel vectors come from a table; multi-cycle cases are hand-written.
module tb_hud_status;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [3:0]  scale = 4'd1;
  logic        game_reset = 1'b0;
  logic        add_valid = 1'b0;
  logic [7:0]  add_bcd = '0;
  logic        add_ready;
  logic        life_lost = 1'b0;
  logic        life_gain = 1'b0;
  logic [1:0]  lives;
  logic        game_over;
  logic [15:0] score_bcd;
  logic [2:0]  rgb;

  int n_chk = 0;
  int n_fail = 0;
  int model = 0;

  hud_status dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .scale(scale),
    .game_reset(game_reset), .add_valid(add_valid),
    .add_bcd(add_bcd), .add_ready(add_ready),
    .life_lost(life_lost), .life_gain(life_gain),
    .lives(lives), .game_over(game_over),
    .score_bcd(score_bcd), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] sc;
    logic [2:0] e;
  } vec_t;

  vec_t vt[26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pchk(input string nm, input logic [9:0] x,
                      input logic [9:0] y, input logic [3:0] sc,
                      input logic [2:0] e);
    pix_x = x;
    pix_y = y;
    scale = sc;
    tick();
    chk(nm, 32'(rgb), 32'(e));
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_add(input logic [7:0] v, input bit inject,
                        output int lowcnt, output logic [15:0] mid);
    int w;
    int hi;
    int lo;
    w = 0;
    while (!add_ready && w < 20) begin
      w++;
      tick();
    end
    if (!add_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL add_ready_wait: got 0 expected 1");
    end
    add_valid = 1'b1;
    add_bcd   = v;
    tick();
    add_valid = 1'b0;
    lowcnt = 0;
    mid = '0;
    while (!add_ready && lowcnt < 20) begin
      add_valid = inject && (lowcnt < 3);
      add_bcd   = 8'h50;
      if (lowcnt == 4) mid = score_bcd;
      lowcnt++;
      tick();
    end
    add_valid = 1'b0;
    hi = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    model = model + hi * 10 + lo;
    if (model > 9999) model = 9999;
  endtask

  task automatic pulse_lives(input logic l, input logic g);
    life_lost = l;
    life_gain = g;
    tick();
    life_lost = 1'b0;
    life_gain = 1'b0;
  endtask

  initial begin
    int lc;
    int cnt;
    int vis;
    logic [15:0] mid;

    vt[0]  = '{10'd41,  10'd20, 4'd1, 3'b111};
    vt[1]  = '{10'd40,  10'd20, 4'd1, 3'b000};
    vt[2]  = '{10'd40,  10'd21, 4'd1, 3'b111};
    vt[3]  = '{10'd48,  10'd20, 4'd1, 3'b111};
    vt[4]  = '{10'd47,  10'd20, 4'd1, 3'b000};
    vt[5]  = '{10'd77,  10'd22, 4'd1, 3'b111};
    vt[6]  = '{10'd77,  10'd23, 4'd1, 3'b000};
    vt[7]  = '{10'd79,  10'd25, 4'd1, 3'b111};
    vt[8]  = '{10'd80,  10'd22, 4'd1, 3'b000};
    vt[9]  = '{10'd83,  10'd20, 4'd1, 3'b010};
    vt[10] = '{10'd82,  10'd21, 4'd1, 3'b010};
    vt[11] = '{10'd90,  10'd20, 4'd1, 3'b000};
    vt[12] = '{10'd506, 10'd20, 4'd1, 3'b100};
    vt[13] = '{10'd500, 10'd20, 4'd1, 3'b000};
    vt[14] = '{10'd500, 10'd24, 4'd1, 3'b100};
    vt[15] = '{10'd539, 10'd27, 4'd1, 3'b100};
    vt[16] = '{10'd552, 10'd27, 4'd1, 3'b000};
    vt[17] = '{10'd41,  10'd19, 4'd1, 3'b000};
    vt[18] = '{10'd41,  10'd27, 4'd1, 3'b000};
    vt[19] = '{10'd500, 10'd28, 4'd1, 3'b000};
    vt[20] = '{10'd127, 10'd20, 4'd2, 3'b010};
    vt[21] = '{10'd125, 10'd20, 4'd2, 3'b000};
    vt[22] = '{10'd41,  10'd20, 4'd0, 3'b111};
    vt[23] = '{10'd42,  10'd21, 4'd2, 3'b111};
    vt[24] = '{10'd41,  10'd21, 4'd2, 3'b000};
    vt[25] = '{10'd512, 10'd20, 4'd2, 3'b100};

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_score", 32'(score_bcd), 32'h0);
    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_add_ready", 32'(add_ready), 32'd1);
    chk("rst_rgb", 32'(rgb), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 26; i++)
      pchk($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].sc, vt[i].e);

    pchk("lat_pre", 10'd125, 10'd20, 4'd2, 3'b000);
    pix_x = 10'd127;
    #1;
    chk("lat_hold", 32'(rgb), 32'd0);
    tick();
    chk("lat_edge", 32'(rgb), 32'b010);

    do_add(8'h95, 1'b0, lc, mid);
    chk("add95_score", 32'(score_bcd), 32'(to_bcd(model)));
    chk("add95_busy", 32'(lc), 32'd5);
    do_add(8'h07, 1'b1, lc, mid);
    chk("add07_busy", 32'(lc), 32'd5);
    chk("add07_mid", 32'(mid), 32'h0095);
    chk("add07_score", 32'(score_bcd), 32'h0102);
    pchk("d102_s0_one", 10'd84, 10'd20, 4'd1, 3'b010);
    pchk("d102_s0_gap", 10'd83, 10'd20, 4'd1, 3'b000);
    pchk("d102_s1_zero", 10'd91, 10'd20, 4'd1, 3'b010);
    pchk("d102_s2_two", 10'd97, 10'd26, 4'd1, 3'b010);
    pchk("d102_s3_none", 10'd105, 10'd26, 4'd1, 3'b000);
    do_add(8'hFA, 1'b0, lc, mid);
    chk("clamp_score", 32'(score_bcd), 32'h0201);

    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
    model = 0;
    chk("greset_score", 32'(score_bcd), 32'h0);
    for (int i = 0; i < 100; i++) do_add(8'h99, 1'b0, lc, mid);
    chk("sum9900", 32'(score_bcd), 32'(to_bcd(model)));
    do_add(8'h90, 1'b0, lc, mid);
    chk("sum9990", 32'(score_bcd), 32'h9990);
    do_add(8'h99, 1'b1, lc, mid);
    chk("sat9999", 32'(score_bcd), 32'h9999);
    do_add(8'h01, 1'b0, lc, mid);
    chk("sat_hold", 32'(score_bcd), 32'h9999);

    pix_x = 10'd539;
    pix_y = 10'd24;
    scale = 4'd1;
    pulse_lives(1'b1, 1'b0);
    chk("lost_lives", 32'(lives), 32'd2);
    tick();
    chk("ghost_at_32", 32'(rgb), 32'd0);
    pchk("icon1_on", 10'd519, 10'd24, 4'd1, 3'b100);
    pix_x = 10'd539;
    tick();
    cnt = 32;
    vis = 0;
    for (int f = 0; f < 34; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (cnt > 0) cnt--;
      tick();
      chk($sformatf("blink_f%0d", f), 32'(rgb),
          ((cnt != 0) && ((cnt & 4) != 0)) ? 32'b100 : 32'b000);
      if (rgb == 3'b100) vis++;
    end
    chk("blink_frames", 32'(vis), 32'd16);

    pulse_lives(1'b1, 1'b1);
    chk("lost_gain_same", 32'(lives), 32'd2);
    pulse_lives(1'b0, 1'b1);
    chk("gain", 32'(lives), 32'd3);
    pulse_lives(1'b0, 1'b1);
    chk("gain_ceiling", 32'(lives), 32'd3);
    pulse_lives(1'b1, 1'b0);
    pulse_lives(1'b1, 1'b0);
    pulse_lives(1'b1, 1'b0);
    chk("lives_zero", 32'(lives), 32'd0);
    chk("go_lag", 32'(game_over), 32'd0);
    tick();
    chk("go_set", 32'(game_over), 32'd1);
    pulse_lives(1'b1, 1'b0);
    chk("no_underflow", 32'(lives), 32'd0);
    chk("go_hold", 32'(game_over), 32'd1);

    add_valid = 1'b1;
    add_bcd   = 8'h05;
    tick();
    add_valid = 1'b0;
    chk("abort_busy", 32'(add_ready), 32'd0);
    tick();
    game_reset = 1'b1;
    tick();
    game_reset = 1'b0;
    chk("abort_ready", 32'(add_ready), 32'd1);
    chk("abort_score", 32'(score_bcd), 32'h0);
    chk("abort_lives", 32'(lives), 32'd3);
    chk("abort_go", 32'(game_over), 32'd0);
    repeat (6) tick();
    chk("abort_no_commit", 32'(score_bcd), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
